parity_check_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one serial even-parity checking unit among NREQ requesters. Each requester presents a W-bit word with a request. The block grants one requester, latches its word, and computes the parity flag bit-serially over W cycles. The flag is 1 when the word has an odd number of ones and 0 when it has an even number. The block then returns the flag with the requester ID over a valid/ready handshake. It sits between the nibble-producing sources and the downstream parity-error logic, replacing per-source combinational checkers.

---
 rtl/parity_check_arbiter.sv | 161 ++++++++++++++++
 tb/tb_parity_check_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/parity_check_arbiter.sv
// parity_check_arbiter
// Round-robin arbiter in front of one shared bit-serial parity checker.
// A granted requester's word is latched, folded one bit per cycle into an
// XOR accumulator, and the resulting odd-parity flag is returned with the
// requester index over a valid/ready handshake.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req         per-requester request, held until its gnt bit is seen
//   data        flattened words, requester i on data[i*W +: W]
//   gnt         one-hot single-cycle grant, word captured on the same edge
//   busy        high whenever the FSM is not IDLE
//   res_valid   result valid, held until accepted
//   res_id      index of the requester the result belongs to
//   res_parity  1 when the word held an odd number of ones
//   res_ready   consumer accept
module parity_check_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4,
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic              res_parity,
  input  logic              res_ready
);

  localparam int unsigned CNTW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [IDW-1:0]    res_id_q, res_id_d;
  logic              par_q, par_d;
  logic [W-1:0]      sh_q, sh_d;
  logic              acc_q, acc_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]    id_q, id_d;

  logic              found_c;
  int unsigned       win_c;
  int unsigned       idx_c;
  int unsigned       nxt_c;

  // Round-robin search: first asserted request at or above ptr, wrapping.
  always_comb begin
    found_c = 1'b0;
    win_c   = 0;
    idx_c   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_c = int'(ptr_q) + k;
      if (idx_c >= NREQ) idx_c = idx_c - NREQ;
      if (!found_c && req[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
    nxt_c = win_c + 1;
    if (nxt_c >= NREQ) nxt_c = 0;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = '0;
    valid_d  = valid_q;
    res_id_d = res_id_q;
    par_d    = par_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    id_d     = id_q;

    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          gnt_d[win_c] = 1'b1;
          sh_d         = data[win_c*W +: W];
          id_d         = IDW'(win_c);
          acc_d        = 1'b0;
          cnt_d        = '0;
          ptr_d        = IDW'(nxt_c);
          state_d      = COMPUTE;
        end
      end
      COMPUTE: begin
        acc_d = acc_q ^ sh_q[0];
        sh_d  = sh_q >> 1;
        cnt_d = cnt_q + CNTW'(1);
        // Last bit folds straight into the result register.
        if (cnt_q == CNTW'(W - 1)) begin
          par_d    = acc_q ^ sh_q[0];
          res_id_d = id_q;
          valid_d  = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (res_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      res_id_q <= '0;
      par_q    <= 1'b0;
      sh_q     <= '0;
      acc_q    <= 1'b0;
      cnt_q    <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      res_id_q <= res_id_d;
      par_q    <= par_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
    end
  end

  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign res_valid  = valid_q;
  assign res_id     = res_id_q;
  assign res_parity = par_q;

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Directed self-checking bench for parity_check_arbiter (NREQ=4, W=4).
// Inputs are driven and outputs sampled on the falling edge.
module tb_parity_check_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] data;
  logic [3:0]  gnt;
  logic        busy;
  logic        res_valid;
  logic [1:0]  res_id;
  logic        res_parity;
  logic        res_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_check_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data       (data),
    .gnt        (gnt),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_parity (res_parity),
    .res_ready  (res_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Serve one request from IDLE with res_ready high; checks grant, latency and result.
  task automatic serve(input string tag, input logic [3:0] r, input logic [3:0] eg,
                       input logic [1:0] eid, input logic ep);
    int bad;
    req = r;
    tick();
    check({tag, "_gnt"}, gnt, eg);
    check({tag, "_busy"}, busy, 1);
    req = r & ~eg;
    tick();
    check({tag, "_gnt_off"}, gnt, 0);
    bad = 0;
    for (int i = 0; i < int'(W) - 2; i++) begin
      tick();
      if (res_valid) bad++;
    end
    check({tag, "_early"}, bad, 0);
    tick();
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_id"}, res_id, eid);
    check({tag, "_par"}, res_parity, ep);
    tick();
    check({tag, "_drop"}, res_valid, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  // Grant requester 2, reset two edges into COMPUTE, confirm nothing emerges.
  task automatic abort_case(input string tag);
    int bad;
    req = 4'b0100;
    tick();
    check({tag, "_pre_gnt"}, gnt, 4'b0100);
    req = '0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_gnt"}, gnt, 0);
    check({tag, "_rst_busy"}, busy, 0);
    check({tag, "_rst_valid"}, res_valid, 0);
    check({tag, "_rst_id"}, res_id, 0);
    check({tag, "_rst_par"}, res_parity, 0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < int'(W) + 2; i++) begin
      tick();
      if (res_valid || busy) bad++;
    end
    check({tag, "_no_result"}, bad, 0);
  endtask

  initial begin
    int gidx [8];
    int gcyc [8];
    int n;
    int multi;
    int bad;

    rst_n     = 1'b0;
    req       = '0;
    data      = '0;
    res_ready = 1'b1;
    @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_id", res_id, 0);
    check("rst_par", res_parity, 0);
    tick();
    rst_n = 1'b1;

    // Requester 0, word 1011 -> odd.
    data = 16'h000B;
    serve("t1", 4'b0001, 4'b0001, 2'd0, 1'b1);

    // Requester 2 with even-weight words.
    data = 16'h0600;
    serve("t2a", 4'b0100, 4'b0100, 2'd2, 1'b0);
    data = 16'h0000;
    serve("t2b", 4'b0100, 4'b0100, 2'd2, 1'b0);
    data = 16'h0F00;
    serve("t2c", 4'b0100, 4'b0100, 2'd2, 1'b0);

    // All four requesting continuously.
    do_reset();
    data = 16'hF731;
    req  = 4'b1111;
    n = 0;
    multi = 0;
    for (int i = 0; i < 8; i++) begin
      gidx[i] = 99;
      gcyc[i] = 0;
    end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (gnt != 4'b0000) begin
        if ($countones(gnt) != 1) multi++;
        if (n < 8) begin
          for (int b = 0; b < 4; b++) if (gnt[b]) gidx[n] = b;
          gcyc[n] = cyc;
          n++;
        end
      end
    end
    check("t3_count", (n >= 5), 1);
    check("t3_g0", gidx[0], 0);
    check("t3_g1", gidx[1], 1);
    check("t3_g2", gidx[2], 2);
    check("t3_g3", gidx[3], 3);
    check("t3_g4", gidx[4], 0);
    for (int i = 1; i < 5; i++) check("t3_gap", gcyc[i] - gcyc[i-1], 6);
    check("t3_onehot", multi, 0);
    req = '0;
    for (int i = 0; i < 10; i++) tick();
    check("t3_drained", busy, 0);

    // Back-pressure with a pending request.
    do_reset();
    data      = 16'h0070;
    res_ready = 1'b0;
    req       = 4'b0010;
    tick();
    check("t4_gnt", gnt, 4'b0010);
    for (int i = 0; i < int'(W) - 1; i++) tick();
    tick();
    check("t4_valid", res_valid, 1);
    check("t4_id", res_id, 1);
    check("t4_par", res_parity, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid !== 1'b1 || res_id !== 2'd1 || res_parity !== 1'b1) bad++;
      if (busy !== 1'b1 || gnt !== 4'b0000) bad++;
    end
    check("t4_hold", bad, 0);
    res_ready = 1'b1;
    tick();
    check("t4_accept", res_valid, 0);
    check("t4_no_gnt_accept", gnt, 0);
    tick();
    check("t4_regrant", gnt, 4'b0010);
    req = '0;
    for (int i = 0; i < 8; i++) tick();
    check("t4_drained", busy, 0);

    // Reset in the middle of COMPUTE.
    do_reset();
    data = 16'h0B00;
    abort_case("t5a");
    serve("t5_post", 4'b0100, 4'b0100, 2'd2, 1'b1);
    abort_case("t5b");
    serve("t5_ptr", 4'b1100, 4'b0100, 2'd2, 1'b1);

    // Pointer wrap after requester 3.
    do_reset();
    data = 16'h3001;
    serve("t6a", 4'b1000, 4'b1000, 2'd3, 1'b0);
    serve("t6b", 4'b1001, 4'b0001, 2'd0, 1'b1);
    serve("t6c", 4'b1000, 4'b1000, 2'd3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
